// File: rtl/rx_deserializer_pkg.sv
// Shared UART definitions: default frame width, oversampling ratio, receiver
// FSM encodings and a constant-evaluable clog2 helper.
package uart_defs;

    localparam int DEF_DATA_BITS = 8;
    localparam int SAMPLE_RATIO  = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rx_deserializer_fifo.sv
// Byte FIFO with extra-MSB pointers; full when MSBs differ and indices match.
module byte_fifo
    import uart_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    sample_clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head_data,
    output logic                    empty,
    output logic                    full,
    output logic [clog2(DEPTH):0]   level
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign level     = wr_ptr_r - rd_ptr_r;
    assign head_data = mem_r[rd_ptr_r[AW-1:0]];

    // A push into a full FIFO is only accepted when a pop frees the slot.
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage and pointer update.
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/rx_deserializer.sv
// UART receive deserializer: assembles sampled bits LSB-first, queues bytes,
// flags overruns and discards partial frames whose sample pulses stop.
module rx_deserializer
    import uart_defs::*;
#(
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_TIMEOUT = 48
) (
    input  logic                         sample_clk,
    input  logic                         rst_n,
    input  logic                         din,
    input  logic                         sample_sig,
    output logic [DATA_BITS-1:0]         data_out,
    output logic                         data_valid,
    input  logic                         data_ready,
    output logic [clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                         overrun,
    input  logic                         clr_err,
    output logic                         frame_drop,
    output logic                         rx_busy
);

    localparam int BCW = clog2(DATA_BITS + 1);
    localparam int GCW = clog2(GAP_TIMEOUT + 1);

    rx_state_e            state_r;
    logic [BCW-1:0]       bit_cnt_r;
    logic [GCW-1:0]       gap_cnt_r;
    logic [DATA_BITS-1:0] shreg_r;
    logic                 frame_drop_r;
    logic                 rx_busy_r;
    logic                 overrun_r;

    logic [DATA_BITS-1:0] next_shreg_s;
    logic                 complete_s;
    logic                 pop_s;
    logic                 empty_s;
    logic                 full_s;
    logic [DATA_BITS-1:0] head_s;

    generate
        if (DATA_BITS == 1) begin : g_single
            assign next_shreg_s = din;
        end else begin : g_multi
            assign next_shreg_s = {din, shreg_r[DATA_BITS-1:1]};
        end
    endgenerate

    // Byte completion: the sample pulse that brings the bit count to DATA_BITS.
    always_comb begin
        complete_s = 1'b0;
        if (sample_sig) begin
            case (state_r)
                IDLE:    complete_s = (DATA_BITS == 1);
                SHIFT:   complete_s = (bit_cnt_r == BCW'(DATA_BITS - 1));
                default: complete_s = 1'b0;
            endcase
        end else begin
            complete_s = 1'b0;
        end
    end

    // Receive FSM with shift register, bit/gap counters and registered flags.
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            bit_cnt_r    <= '0;
            gap_cnt_r    <= '0;
            shreg_r      <= '0;
            frame_drop_r <= 1'b0;
            rx_busy_r    <= 1'b0;
        end else begin
            frame_drop_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sample_sig) begin
                        shreg_r   <= next_shreg_s;
                        gap_cnt_r <= '0;
                        if (complete_s) begin
                            bit_cnt_r <= '0;
                        end else begin
                            bit_cnt_r <= BCW'(1);
                            state_r   <= SHIFT;
                            rx_busy_r <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (sample_sig) begin
                        shreg_r   <= next_shreg_s;
                        gap_cnt_r <= '0;
                        if (complete_s) begin
                            bit_cnt_r <= '0;
                            state_r   <= IDLE;
                            rx_busy_r <= 1'b0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BCW'(1);
                        end
                    end else if (gap_cnt_r == GCW'(GAP_TIMEOUT - 1)) begin
                        bit_cnt_r    <= '0;
                        gap_cnt_r    <= '0;
                        state_r      <= IDLE;
                        rx_busy_r    <= 1'b0;
                        frame_drop_r <= 1'b1;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GCW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bit_cnt_r <= '0;
                    gap_cnt_r <= '0;
                    rx_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign pop_s = !empty_s && data_ready;

    // Sticky overrun: a dropped byte outranks a simultaneous clear.
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (complete_s && full_s && !pop_s) begin
            overrun_r <= 1'b1;
        end else if (clr_err) begin
            overrun_r <= 1'b0;
        end
    end

    byte_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sample_clk (sample_clk),
        .rst_n      (rst_n),
        .push       (complete_s),
        .push_data  (next_shreg_s),
        .pop        (pop_s),
        .head_data  (head_s),
        .empty      (empty_s),
        .full       (full_s),
        .level      (fifo_level)
    );

    assign data_valid = !empty_s;
    assign data_out   = empty_s ? '0 : head_s;
    assign overrun    = overrun_r;
    assign frame_drop = frame_drop_r;
    assign rx_busy    = rx_busy_r;

endmodule

// File: tb/tb_rx_deserializer.sv
// Directed bench for rx_deserializer: inputs change on negedge, outputs are
// checked on the following negedge against hand-computed values.
module tb_rx_deserializer;

    logic       sample_clk;
    logic       rst_n;
    logic       din;
    logic       sample_sig;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic [2:0] fifo_level;
    logic       overrun;
    logic       clr_err;
    logic       frame_drop;
    logic       rx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    rx_deserializer #(
        .DATA_BITS   (8),
        .FIFO_DEPTH  (4),
        .GAP_TIMEOUT (48)
    ) dut (
        .sample_clk (sample_clk),
        .rst_n      (rst_n),
        .din        (din),
        .sample_sig (sample_sig),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .fifo_level (fifo_level),
        .overrun    (overrun),
        .clr_err    (clr_err),
        .frame_drop (frame_drop),
        .rx_busy    (rx_busy)
    );

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sample_clk);
    endtask

    // One sample pulse; returns at the negedge right after the capturing edge.
    task automatic pulse_ex(input logic b, input logic rdy, input logic clr);
        @(negedge sample_clk);
        din        = b;
        sample_sig = 1'b1;
        data_ready = rdy;
        clr_err    = clr;
        @(negedge sample_clk);
        sample_sig = 1'b0;
        data_ready = 1'b0;
        clr_err    = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) idle(15);
            pulse_ex(v[i], 1'b0, 1'b0);
        end
    endtask

    task automatic pop_one();
        @(negedge sample_clk);
        data_ready = 1'b1;
        @(negedge sample_clk);
        data_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 1'b1;
        sample_sig = 1'b0;
        data_ready = 1'b0;
        clr_err    = 1'b0;
        idle(3);
        check("reset_valid", 32'(data_valid), 32'h0);
        check("reset_data", 32'(data_out), 32'h0);
        check("reset_level", 32'(fifo_level), 32'h0);
        check("reset_ovr", 32'(overrun), 32'h0);
        check("reset_drop", 32'(frame_drop), 32'h0);
        check("reset_busy", 32'(rx_busy), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // 0xA5 LSB-first: 1,0,1,0,0,1,0,1
        send_bits(8'hA5, 7);
        check("a5_busy_mid", 32'(rx_busy), 32'h1);
        idle(15);
        check("a5_not_yet", 32'(data_valid), 32'h0);
        pulse_ex(1'b1, 1'b0, 1'b0);
        check("a5_valid", 32'(data_valid), 32'h1);
        check("a5_data", 32'(data_out), 32'hA5);
        check("a5_level", 32'(fifo_level), 32'h1);
        check("a5_busy_end", 32'(rx_busy), 32'h0);
        pop_one();
        check("a5_popped", 32'(data_valid), 32'h0);
        check("a5_gated", 32'(data_out), 32'h0);
        pop_one();
        check("underflow_lvl", 32'(fifo_level), 32'h0);

        // Overflow: 0x01..0x05 with no consumer.
        for (int b = 1; b <= 5; b++) begin
            send_bits(8'(b), 8);
            if (b == 4) begin
                check("ovf_lvl4", 32'(fifo_level), 32'h4);
                check("ovf_none_yet", 32'(overrun), 32'h0);
            end
        end
        check("ovf_set", 32'(overrun), 32'h1);
        check("ovf_lvl_held", 32'(fifo_level), 32'h4);
        for (int b = 1; b <= 4; b++) begin
            check("ovf_drain", 32'(data_out), 32'(b));
            pop_one();
        end
        check("ovf_empty", 32'(data_valid), 32'h0);
        @(negedge sample_clk);
        clr_err = 1'b1;
        @(negedge sample_clk);
        clr_err = 1'b0;
        check("ovf_cleared", 32'(overrun), 32'h0);

        // Full FIFO, pop coincides with the 5th byte's push.
        for (int b = 1; b <= 4; b++) send_bits(8'(b), 8);
        send_bits(8'h05, 7);
        idle(15);
        pulse_ex(1'b0, 1'b1, 1'b0);
        check("pp_level", 32'(fifo_level), 32'h4);
        check("pp_no_ovr", 32'(overrun), 32'h0);
        for (int b = 2; b <= 5; b++) begin
            check("pp_drain", 32'(data_out), 32'(b));
            pop_one();
        end

        // Gap timeout after 3 pulses.
        send_bits(8'hFF, 3);
        idle(47);
        check("to_not_yet", 32'(frame_drop), 32'h0);
        check("to_busy", 32'(rx_busy), 32'h1);
        idle(1);
        check("to_drop", 32'(frame_drop), 32'h1);
        check("to_idle", 32'(rx_busy), 32'h0);
        check("to_no_push", 32'(fifo_level), 32'h0);
        idle(1);
        check("to_pulse_end", 32'(frame_drop), 32'h0);
        send_bits(8'h3C, 8);
        check("to_next_data", 32'(data_out), 32'h3C);
        check("to_next_lvl", 32'(fifo_level), 32'h1);
        pop_one();

        // Asynchronous reset mid-frame with two bytes queued.
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        send_bits(8'h33, 4);
        check("rst_pre_lvl", 32'(fifo_level), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(data_valid), 32'h0);
        check("rst_async_data", 32'(data_out), 32'h0);
        check("rst_async_lvl", 32'(fifo_level), 32'h0);
        check("rst_async_busy", 32'(rx_busy), 32'h0);
        @(negedge sample_clk);
        rst_n = 1'b1;
        send_bits(8'h5A, 8);
        check("rst_new_lvl", 32'(fifo_level), 32'h1);
        check("rst_new_data", 32'(data_out), 32'h5A);
        pop_one();

        // Overrun versus a coincident clear, then a clear on its own.
        for (int b = 8'h61; b <= 8'h65; b++) send_bits(8'(b), 8);
        check("clr_ovr_set", 32'(overrun), 32'h1);
        send_bits(8'h66, 7);
        idle(15);
        pulse_ex(1'b0, 1'b0, 1'b1);
        check("clr_race_ovr", 32'(overrun), 32'h1);
        check("clr_race_lvl", 32'(fifo_level), 32'h4);
        @(negedge sample_clk);
        clr_err = 1'b1;
        @(negedge sample_clk);
        clr_err = 1'b0;
        check("clr_alone", 32'(overrun), 32'h0);
        check("clr_head", 32'(data_out), 32'h61);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_deserializer.md
Name: rx_deserializer

Overview:
Downstream consumer of the UART receive sampler. On each mid-bit `sample_sig` pulse it captures `din` and assembles DATA_BITS bits LSB-first into a byte. Completed bytes go into a small FIFO, which presents them to the host side over a valid/ready handshake. It also flags overruns and drops partial frames whose sample pulses stop arriving.

Parameters:
- DATA_BITS, 8: bits per frame; equals the number of `sample_sig` pulses the sampler emits per frame.
- FIFO_DEPTH, 4: byte FIFO entries; power of two, at least 2.
- GAP_TIMEOUT, 48: number of `sample_clk` cycles without a `sample_sig` pulse, while a frame is partial, after which the partial frame is discarded. Nominal pulse spacing is 16 cycles.

Ports:
- sample_clk  in  1  oversampling clock, shared with the sampler
- rst_n  in  1  asynchronous, active-low reset
- din  in  1  serial line; the same synchronised signal that feeds the sampler
- sample_sig  in  1  one-cycle pulse meaning "capture din this cycle"
- data_out  out  DATA_BITS  FIFO head byte; 0 when data_valid=0
- data_valid  out  1  FIFO non-empty
- data_ready  in  1  consumer accepts the head byte when data_valid && data_ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
- overrun  out  1  sticky; set when a completed byte is dropped because the FIFO is full
- clr_err  in  1  synchronous clear of overrun
- frame_drop  out  1  one-cycle pulse when a partial frame is discarded on timeout
- rx_busy  out  1  high while in state SHIFT

Behaviour:
- Interface: one clock, `sample_clk`. Reset `rst_n` is asynchronous and active-low. All state updates on the posedge of `sample_clk`.
- Reset values:
  - FSM = IDLE; bit_cnt = 0; shift register = 0; gap_cnt = 0.
  - FIFO pointers = 0, so fifo_level = 0 and data_valid = 0.
  - data_out = 0, overrun = 0, frame_drop = 0, rx_busy = 0.
  - Reset mid-frame discards the partial byte and the FIFO contents.
- FSM states: IDLE, SHIFT.
- IDLE:
  - On sample_sig = 1: shreg <= {din, shreg[DATA_BITS-1:1]}, bit_cnt <= 1, gap_cnt <= 0, go to SHIFT.
  - Exception: if DATA_BITS = 1, the byte completes immediately and the FSM stays in IDLE.
- SHIFT, on sample_sig = 1:
  - Shift in as above; bit_cnt++; gap_cnt <= 0.
  - If the new bit_cnt equals DATA_BITS: the byte is complete. Push {din, shreg[DATA_BITS-1:1]} to the FIFO on that same edge, bit_cnt <= 0, go to IDLE.
- SHIFT, on sample_sig = 0:
  - gap_cnt++.
  - When gap_cnt = GAP_TIMEOUT-1: discard the partial frame, bit_cnt <= 0, go to IDLE, frame_drop = 1 for the next cycle only.
  - Nothing is pushed and overrun is unaffected.
- Latency: byte completes on edge E → data_valid = 1 in the cycle after E, provided the FIFO was empty.
- Bit order: first captured bit is bit 0 (LSB).
- FIFO:
  - Pop occurs on an edge where data_valid && data_ready.
  - data_out is combinational from the head entry, gated to 0 when empty.
  - data_ready while empty has no effect; pointers never underflow.
- Push and pop in the same edge: both occur and fifo_level is unchanged. This applies when full as well: the push is accepted because the pop frees the slot.
- Push while full with no pop: the byte is dropped, FIFO contents and pointers are unchanged, overrun <= 1.
- overrun clear:
  - clr_err = 1 clears overrun on the next edge.
  - A new overrun in the same cycle as clr_err wins: overrun stays 1.
- Pointers are log2(FIFO_DEPTH)+1 bits. Wrap-around is natural modulo; full = MSBs differ and the rest are equal.
- rx_busy = (state == SHIFT), registered with the state.

Decomposition:
- Shared package `uart_defs`: DATA_BITS default, SAMPLE_RATIO, FSM state encodings (IDLE = 0, SHIFT = 1), and a clog2 helper function. The sampler and transmitter share these.
- One sub-module: `byte_fifo` (parameters WIDTH, DEPTH). Ports: sample_clk, rst_n, push, push_data, pop, head_data, empty, full, level. The overrun decision stays in `rx_deserializer`.

Test Plan:
- Byte 0xA5 sent as 8 pulses spaced 16 cycles, din = 1,0,1,0,0,1,0,1 → data_valid rises 1 cycle after the 8th pulse edge; data_out = 0xA5; fifo_level = 1; rx_busy low after the byte.
- data_ready held 0, five bytes 0x01..0x05 (FIFO_DEPTH = 4) → fifo_level = 4; overrun = 1 after the 5th byte. Draining returns 0x01, 0x02, 0x03, 0x04; 0x05 is lost.
- FIFO full, data_ready = 1 on the same edge as the 5th byte's push → level stays 4; overrun stays 0; drained order is 0x02..0x05.
- 3 pulses, then silence for 48 cycles → frame_drop pulses 1 cycle at gap_cnt = 47; FSM = IDLE. The next full frame 0x3C is received correctly.
- rst_n low mid-frame, after 4 bits, with 2 bytes queued → all outputs 0 immediately (asynchronous). A frame after release yields only the new byte.
- overrun set, then clr_err = 1 coinciding with another overflow → overrun remains 1. clr_err alone on a later cycle clears it.
